seq_det_ctrl: RTL and testbench



---
 rtl/seq_det_ctrl.sv | 77 +++++++
 tb/tb_seq_det_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serialises words MSB-first into a sequence detector and counts its matches
module seq_det_ctrl #(
    parameter int WIDTH = 8,
    parameter int DRAIN = 0,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    output logic             fsm_reset,
    output logic             fsm_x,
    input  logic             fsm_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             overflow
);
    localparam int CMAX = (WIDTH > DRAIN) ? WIDTH : DRAIN;
    localparam int BW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bcnt;
    logic             last_bit, last_drain, accept, sample;

    assign last_bit   = bcnt == BW'(WIDTH - 1);
    assign last_drain = bcnt == BW'(DRAIN - 1);
    assign accept     = state == S_IDLE && in_valid;
    assign sample     = state == S_SHIFT || state == S_DRAIN;

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_nx;

    // next-state and outputs; the detector reset also follows the system reset directly
    always_comb begin
        state_nx  = state;
        in_ready  = state == S_IDLE;
        busy      = state != S_IDLE;
        done      = state == S_DONE;
        fsm_x     = state == S_SHIFT ? sreg[WIDTH-1] : 1'b0;
        fsm_reset = reset || state == S_CLR;
        case (state)
            S_IDLE:  state_nx = in_valid ? (in_clear ? S_CLR : S_SHIFT) : S_IDLE;
            S_CLR:   state_nx = S_SHIFT;
            S_SHIFT: state_nx = last_bit ? (DRAIN > 0 ? S_DRAIN : S_DONE) : S_SHIFT;
            S_DRAIN: state_nx = last_drain ? S_DONE : S_DRAIN;
            default: state_nx = S_IDLE;
        endcase
    end

    // shift register, bit/drain counter and saturating match counter
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sreg      <= '0;
            bcnt      <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) sreg <= in_data;
            else if (state == S_SHIFT) sreg <= {sreg[WIDTH-2:0], 1'b0};
            bcnt <= ((state == S_SHIFT && !last_bit) || (state == S_DRAIN && !last_drain)) ? bcnt + 1'b1 : '0;
            if (accept) begin
                match_cnt <= '0;
                overflow  <= 1'b0;
            end else if (sample && fsm_z) begin
                if (&match_cnt) overflow <= 1'b1;
                else            match_cnt <= match_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: randomized and directed checks of seq_det_ctrl against a 101-detector reference
module tb_seq_det_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // instance A: DRAIN=0 with a behavioural overlapping Mealy 101 detector
    logic       v_a, rdy_a, clr_a, frst_a, x_a, z_a, busy_a, done_a, ovf_a;
    logic [7:0] d_a;
    logic [3:0] cnt_a;
    logic [1:0] hist;
    seq_det_ctrl #(.WIDTH(8), .DRAIN(0), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .in_valid(v_a), .in_ready(rdy_a), .in_data(d_a), .in_clear(clr_a),
        .fsm_reset(frst_a), .fsm_x(x_a), .fsm_z(z_a), .busy(busy_a), .done(done_a),
        .match_cnt(cnt_a), .overflow(ovf_a));

    // detector stub remembers the last two bits seen on x
    always_ff @(posedge clk or posedge frst_a)
        if (frst_a) hist <= 2'b00;
        else        hist <= {hist[0], x_a};
    assign z_a = hist == 2'b10 && x_a;

    // instance B: DRAIN=1 with scripted z
    logic       v_b, rdy_b, clr_b, frst_b, x_b, z_b, busy_b, done_b, ovf_b;
    logic [7:0] d_b;
    logic [3:0] cnt_b;
    seq_det_ctrl #(.WIDTH(8), .DRAIN(1), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .in_valid(v_b), .in_ready(rdy_b), .in_data(d_b), .in_clear(clr_b),
        .fsm_reset(frst_b), .fsm_x(x_b), .fsm_z(z_b), .busy(busy_b), .done(done_b),
        .match_cnt(cnt_b), .overflow(ovf_b));

    // instance C: CNT_W=2 with scripted z
    logic       v_c, rdy_c, clr_c, frst_c, x_c, z_c, busy_c, done_c, ovf_c;
    logic [7:0] d_c;
    logic [1:0] cnt_c;
    seq_det_ctrl #(.WIDTH(8), .DRAIN(0), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .in_valid(v_c), .in_ready(rdy_c), .in_data(d_c), .in_clear(clr_c),
        .fsm_reset(frst_c), .fsm_x(x_c), .fsm_z(z_c), .busy(busy_c), .done(done_c),
        .match_cnt(cnt_c), .overflow(ovf_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // overlapping 101 matches ending inside the word; at least two zeros precede every word
    function automatic int count101(input logic [7:0] w);
        logic [9:0] s;
        int n;
        s = {2'b00, w};
        n = 0;
        for (int j = 0; j < 8; j++) if (s[7-j +: 3] == 3'b101) n++;
        return n;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_chk++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b%b%b want 111", rdy_a, rdy_b, rdy_c); end
        n_chk++; if (cnt_a !== 4'd0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_cnt got %0d/%b want 0/0", cnt_a, ovf_a); end
        n_chk++; if (done_a !== 1'b0 || busy_a !== 1'b0 || x_a !== 1'b0 || frst_a !== 1'b0) begin n_fail++; $display("FAIL reset_outs got done=%b busy=%b x=%b frst=%b want 0000", done_a, busy_a, x_a, frst_a); end
    endtask

    task automatic test_serialise();
        logic [7:0] w;
        w = 8'hA5;
        z_c = 1'b0; d_c = w; clr_c = 1'b1; v_c = 1'b1;
        step();
        v_c = 1'b0;
        n_chk++; if (frst_c !== 1'b1 || busy_c !== 1'b1 || rdy_c !== 1'b0) begin n_fail++; $display("FAIL ser_clr got frst=%b busy=%b rdy=%b want 1 1 0", frst_c, busy_c, rdy_c); end
        for (int i = 0; i < 8; i++) begin
            step();
            n_chk++; if (x_c !== w[7-i] || frst_c !== 1'b0 || done_c !== 1'b0) begin n_fail++; $display("FAIL ser_bit%0d got x=%b frst=%b done=%b want x=%b 0 0", i, x_c, frst_c, done_c, w[7-i]); end
        end
        step();
        n_chk++; if (done_c !== 1'b1 || cnt_c !== 2'd0) begin n_fail++; $display("FAIL ser_done got done=%b cnt=%0d want 1 0", done_c, cnt_c); end
        step();
        n_chk++; if (done_c !== 1'b0 || rdy_c !== 1'b1) begin n_fail++; $display("FAIL ser_after got done=%b rdy=%b want 0 1", done_c, rdy_c); end
    endtask

    task automatic test_count_drain();
        z_b = 1'b0; d_b = 8'($urandom); clr_b = 1'b0; v_b = 1'b1;
        step();
        v_b = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            z_b = (c == 3 || c == 6 || c == 9);
            n_chk++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL drain_early cycle %0d got done=1 want 0", c); end
            step();
        end
        z_b = 1'b1;
        n_chk++; if (done_b !== 1'b1 || cnt_b !== 4'd3 || ovf_b !== 1'b0) begin n_fail++; $display("FAIL drain_done got done=%b cnt=%0d ovf=%b want 1 3 0", done_b, cnt_b, ovf_b); end
        step();
        z_b = 1'b0;
        n_chk++; if (done_b !== 1'b0 || cnt_b !== 4'd3) begin n_fail++; $display("FAIL drain_hold got done=%b cnt=%0d want 0 3", done_b, cnt_b); end
    endtask

    task automatic test_saturation();
        z_c = 1'b1; d_c = 8'($urandom); clr_c = 1'b0; v_c = 1'b1;
        step();
        v_c = 1'b0;
        for (int c = 0; c < 20 && done_c !== 1'b1; c++) step();
        n_chk++; if (done_c !== 1'b1 || cnt_c !== 2'd3 || ovf_c !== 1'b1) begin n_fail++; $display("FAIL sat got done=%b cnt=%0d ovf=%b want 1 3 1", done_c, cnt_c, ovf_c); end
        step();
        z_c = 1'b0; v_c = 1'b1;
        step();
        v_c = 1'b0;
        n_chk++; if (cnt_c !== 2'd0 || ovf_c !== 1'b0) begin n_fail++; $display("FAIL sat_clear got cnt=%0d ovf=%b want 0 0", cnt_c, ovf_c); end
        for (int c = 0; c < 20 && done_c !== 1'b1; c++) step();
        step();
    endtask

    task automatic run_word_a(input logic [7:0] w, input logic c);
        int k;
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int i = 0; i < idle; i++) step();
        for (int i = 0; i < 30 && rdy_a !== 1'b1; i++) step();
        n_chk++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL word_ready timeout got rdy=%b want 1", rdy_a); end
        d_a = w; clr_a = c; v_a = 1'b1;
        step();
        v_a = 1'b0; d_a = 8'($urandom);
        k = 1;
        while (done_a !== 1'b1 && k < 30) begin step(); k++; end
        n_chk++; if (k !== (c ? 10 : 9)) begin n_fail++; $display("FAIL word_latency w=%h clr=%b got %0d want %0d", w, c, k, c ? 10 : 9); end
        n_chk++; if (cnt_a !== 4'(count101(w)) || ovf_a !== 1'b0) begin n_fail++; $display("FAIL word_count w=%h got %0d ovf=%b want %0d 0", w, cnt_a, ovf_a, count101(w)); end
        step();
    endtask

    task automatic test_integration();
        run_word_a(8'b1010_1000, 1'b1);
        run_word_a(8'b0100_0000, 1'b0);
        run_word_a(8'b1011_0101, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) run_word_a(8'($urandom), 1'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] w;
        logic acc;
        int cyc, last_acc, n_acc, n_done;
        cyc = 0; last_acc = -1; n_acc = 0; n_done = 0;
        for (int i = 0; i < 30 && rdy_a !== 1'b1; i++) step();
        clr_a = 1'b0; d_a = 8'($urandom); v_a = 1'b1;
        while (n_done < 5 && cyc < 100) begin
            acc = rdy_a;
            w = d_a;
            step();
            cyc++;
            if (acc) begin
                q.push_back(w);
                n_acc++;
                if (last_acc >= 0) begin
                    n_chk++; if (cyc - last_acc !== 10) begin n_fail++; $display("FAIL b2b_spacing got %0d want 10", cyc - last_acc); end
                end
                last_acc = cyc;
                d_a = 8'($urandom);
            end
            if (done_a === 1'b1) begin
                n_done++;
                w = q.size() > 0 ? q.pop_front() : 8'h00;
                n_chk++; if (cnt_a !== 4'(count101(w))) begin n_fail++; $display("FAIL b2b_count w=%h got %0d want %0d", w, cnt_a, count101(w)); end
            end
        end
        v_a = 1'b0;
        n_chk++; if (n_done !== 5 || n_acc !== 5 || q.size() !== 0) begin n_fail++; $display("FAIL b2b_totals got done=%0d acc=%0d pending=%0d want 5 5 0", n_done, n_acc, q.size()); end
        step();
    endtask

    task automatic test_reset_mid_word();
        int n_done;
        n_done = 0;
        for (int i = 0; i < 30 && rdy_a !== 1'b1; i++) step();
        d_a = 8'hFF; clr_a = 1'b0; v_a = 1'b1;
        step();
        v_a = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        #1;
        n_chk++; if (frst_a !== 1'b1 || rdy_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_async got frst=%b rdy=%b busy=%b want 1 1 0", frst_a, rdy_a, busy_a); end
        step(); step();
        reset = 1'b0;
        #1;
        n_chk++; if (cnt_a !== 4'd0 || done_a !== 1'b0 || frst_a !== 1'b0 || x_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state got cnt=%0d done=%b frst=%b x=%b want 0 0 0 0", cnt_a, done_a, frst_a, x_a); end
        for (int i = 0; i < 15; i++) begin
            step();
            if (done_a === 1'b1) n_done++;
        end
        n_chk++; if (n_done !== 0 || rdy_a !== 1'b1) begin n_fail++; $display("FAIL mid_reset_nodone got dones=%0d rdy=%b want 0 1", n_done, rdy_a); end
    endtask

    initial begin
        reset = 1'b1;
        v_a = 1'b0; d_a = '0; clr_a = 1'b0;
        v_b = 1'b0; d_b = '0; clr_b = 1'b0; z_b = 1'b0;
        v_c = 1'b0; d_c = '0; clr_c = 1'b0; z_c = 1'b0;
        test_reset();
        test_serialise();
        test_count_drain();
        test_saturation();
        test_integration();
        test_random();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
